// File: rtl/operand_gen_fwd_if.sv
// ---------------------------------------------------------------------------
// operand_gen_fwd_if
// Decode-side and ID->EX-side handshake bundle for operand_gen_fwd.
//   in_valid / in_ready        : decoded instruction handshake (upstream)
//   addr, op, funct, imm       : instruction PC and decoded fields
//   rs_addr, rt_addr           : source register indices
//   reg_data_1, reg_data_2     : register-file read data for rs / rt
//   out_valid / out_ready      : ID->EX pipeline slot handshake (downstream)
//   operand_1, operand_2       : registered operands presented to EX
// master = environment (decoder + EX stage), slave = operand generator.
// ---------------------------------------------------------------------------
interface operand_gen_fwd_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] addr;
  logic [5:0]            op;
  logic [5:0]            funct;
  logic [15:0]           imm;
  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [DATA_WIDTH-1:0] reg_data_1;
  logic [DATA_WIDTH-1:0] reg_data_2;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;

  modport master (
    output in_valid, addr, op, funct, imm, rs_addr, rt_addr,
           reg_data_1, reg_data_2, out_ready,
    input  in_ready, out_valid, operand_1, operand_2
  );

  modport slave (
    input  in_valid, addr, op, funct, imm, rs_addr, rt_addr,
           reg_data_1, reg_data_2, out_ready,
    output in_ready, out_valid, operand_1, operand_2
  );
endinterface

// File: rtl/operand_gen_fwd.sv
// ---------------------------------------------------------------------------
// operand_gen_fwd
// ID-stage operand generator with result forwarding and load-use stall.
// Resolves rs/rt against FWD_CH forwarding channels (channel 0 youngest),
// selects operand_1/operand_2 per opcode, and registers them into a
// valid/ready ID->EX slot.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : decode handshake + fields, ID->EX handshake + operands
//   fwd_valid       : per-channel register-write valid
//   fwd_pending     : per-channel "data not yet available" (load in flight)
//   fwd_addr        : per-channel destination index, packed REG_ADDR_W each
//   fwd_data        : per-channel result, packed DATA_WIDTH each
//   stall           : combinational load-use stall
//   stall_cycles    : saturating stall-cycle counter (only with
//                     OPGEN_STALL_CNT_EN defined)
//
// Optional feature macro: OPGEN_STALL_CNT_EN
// ---------------------------------------------------------------------------
module operand_gen_fwd #(
  parameter int DATA_WIDTH = 32,
  parameter int FWD_CH     = 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  operand_gen_fwd_if.slave             bus,
  input  logic [FWD_CH-1:0]            fwd_valid,
  input  logic [FWD_CH-1:0]            fwd_pending,
  input  logic [FWD_CH*REG_ADDR_W-1:0] fwd_addr,
  input  logic [FWD_CH*DATA_WIDTH-1:0] fwd_data,
  output logic                         stall
`ifdef OPGEN_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cycles
`endif
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_JALR    = 6'h09;

  typedef struct packed {
    logic                  hazard;
    logic [DATA_WIDTH-1:0] value;
  } src_t;

  // Walk from oldest to youngest so the youngest matching channel is the
  // last writer; a younger non-pending match therefore masks an older
  // pending one.
  function automatic src_t resolve(
    input logic [REG_ADDR_W-1:0]        idx,
    input logic [DATA_WIDTH-1:0]        rf_data,
    input logic [FWD_CH-1:0]            f_valid,
    input logic [FWD_CH-1:0]            f_pending,
    input logic [FWD_CH*REG_ADDR_W-1:0] f_addr,
    input logic [FWD_CH*DATA_WIDTH-1:0] f_data
  );
    src_t res;
    res.hazard = 1'b0;
    res.value  = rf_data;
    if (idx != '0) begin
      for (int i = FWD_CH - 1; i >= 0; i--) begin
        if (f_valid[i] && (f_addr[i*REG_ADDR_W +: REG_ADDR_W] == idx)) begin
          res.hazard = f_pending[i];
          res.value  = f_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    return res;
  endfunction

  src_t                  rs_src;
  src_t                  rt_src;
  logic                  is_alu_mem;
  logic                  is_special;
  logic                  is_jalr;
  logic                  rs_used;
  logic                  rt_used;
  logic                  in_ready;
  logic                  capture;
  logic [DATA_WIDTH-1:0] link;
  logic [DATA_WIDTH-1:0] imm_sext;
  logic [DATA_WIDTH-1:0] imm_zext;
  logic [DATA_WIDTH-1:0] imm_hi;
  logic [DATA_WIDTH-1:0] op1_sel;
  logic [DATA_WIDTH-1:0] op2_sel;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] operand_1_q, operand_1_d;
  logic [DATA_WIDTH-1:0] operand_2_q, operand_2_d;

  always_comb begin
    rs_src = resolve(bus.rs_addr, bus.reg_data_1, fwd_valid, fwd_pending,
                     fwd_addr, fwd_data);
    rt_src = resolve(bus.rt_addr, bus.reg_data_2, fwd_valid, fwd_pending,
                     fwd_addr, fwd_data);
  end

  always_comb begin
    is_alu_mem = 1'b0;
    case (bus.op)
      OP_ADDIU, OP_LUI, OP_ORI, OP_ANDI,
      OP_LB, OP_LW, OP_LBU, OP_SB, OP_SW: is_alu_mem = 1'b1;
      default:                            is_alu_mem = 1'b0;
    endcase
  end

  assign is_special = (bus.op == OP_SPECIAL);
  assign is_jalr    = is_special && (bus.funct == FN_JALR);
  // JALR links through operand_1, so its rs never reaches EX via this block.
  assign rs_used    = is_alu_mem || (is_special && !is_jalr);
  assign rt_used    = is_special;

  assign stall    = bus.in_valid &&
                    ((rs_used && rs_src.hazard) || (rt_used && rt_src.hazard));
  assign in_ready = !stall && (!out_valid_q || bus.out_ready);
  assign capture  = bus.in_valid && in_ready;

  assign link     = bus.addr + DATA_WIDTH'(8);
  assign imm_sext = {{(DATA_WIDTH-16){bus.imm[15]}}, bus.imm};
  assign imm_zext = {{(DATA_WIDTH-16){1'b0}}, bus.imm};
  assign imm_hi   = DATA_WIDTH'({bus.imm, 16'h0000});

  always_comb begin
    op1_sel = '0;
    op2_sel = '0;
    case (bus.op)
      OP_ADDIU, OP_LB, OP_LW, OP_LBU, OP_SB, OP_SW: begin
        op1_sel = rs_src.value;
        op2_sel = imm_sext;
      end
      OP_ANDI, OP_ORI: begin
        op1_sel = rs_src.value;
        op2_sel = imm_zext;
      end
      OP_LUI: begin
        op1_sel = rs_src.value;
        op2_sel = imm_hi;
      end
      OP_SPECIAL: begin
        op1_sel = is_jalr ? link : rs_src.value;
        op2_sel = rt_src.value;
      end
      OP_JAL: begin
        op1_sel = link;
      end
      default: begin
        op1_sel = '0;
        op2_sel = '0;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    operand_1_d = operand_1_q;
    operand_2_d = operand_2_q;
    if (capture) begin
      out_valid_d = 1'b1;
      operand_1_d = op1_sel;
      operand_2_d = op2_sel;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      operand_1_q <= '0;
      operand_2_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      operand_1_q <= operand_1_d;
      operand_2_q <= operand_2_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.operand_1 = operand_1_q;
  assign bus.operand_2 = operand_2_q;

`ifdef OPGEN_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: doc/operand_gen_fwd.md
Name: operand_gen_fwd

Overview:
- Next-generation ID-stage operand generator. Selects operand_1/operand_2 from register-file data, immediates and the link address.
- Adds a parametrised set of forwarding channels, so operands take the newest in-flight result.
- Detects load-use hazards and stalls on them.
- Registers the result into a valid/ready ID→EX pipeline slot, sitting between the register-file read and the EX stage.

Parameters:
- DATA_WIDTH, 32, width of data, address and operand buses
- FWD_CH, 2, number of forwarding channels; channel 0 is the youngest stage (EX), highest index the oldest
- REG_ADDR_W, 5, register index width

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction presented
- in_ready  out  1  block accepts the instruction this cycle
- addr  in  DATA_WIDTH  instruction PC
- op  in  6  opcode field
- funct  in  6  funct field
- imm  in  16  immediate field
- rs_addr  in  REG_ADDR_W  rs index
- rt_addr  in  REG_ADDR_W  rt index
- reg_data_1  in  DATA_WIDTH  register-file rs data
- reg_data_2  in  DATA_WIDTH  register-file rt data
- fwd_valid  in  FWD_CH  channel i carries a register write
- fwd_pending  in  FWD_CH  channel i writes a register whose data is not yet available (load in flight)
- fwd_addr  in  FWD_CH*REG_ADDR_W  destination index per channel, channel i at bits [i*REG_ADDR_W +: REG_ADDR_W]
- fwd_data  in  FWD_CH*DATA_WIDTH  result per channel, packed the same way
- out_valid  out  1  operand register holds a valid instruction
- out_ready  in  1  EX stage consumes the register this cycle
- operand_1  out  DATA_WIDTH  registered operand 1
- operand_2  out  DATA_WIDTH  registered operand 2
- stall  out  1  load-use stall active (combinational)

Behaviour:
- Reset: out_valid=0, operand_1=0, operand_2=0. Reset overrides any simultaneous capture. Reset mid-stall discards the held instruction.
- Source resolution for rs (rt is identical, using rt_addr/reg_data_2):
  - Index 0 always resolves to reg_data; never forwarded, never stalls.
  - Otherwise take the lowest-index channel i with fwd_valid[i]=1 and fwd_addr[i]=rs_addr.
  - If that channel has fwd_pending[i]=1 → hazard. If fwd_pending[i]=0 → use fwd_data[i].
  - If no channel matches → reg_data_1.
  - A pending match on a higher-index channel is masked by an older-data... no: it is masked by any matching lower-index (younger) channel.
- Source usage:
  - rs is used by ADDIU, LUI, ORI, ANDI, LB, LW, LBU, SB, SW, and by SPECIAL except JALR.
  - rt is used by SPECIAL only.
  - Hazards on unused sources are ignored.
- stall = in_valid & (used-rs hazard | used-rt hazard).
- Operand selection (rs_v/rt_v are the resolved values):
  - operand_1:
    - ADDIU, LUI, ORI, ANDI, LB, LW, LBU, SB, SW → rs_v
    - SPECIAL → link if funct==JALR, else rs_v
    - JAL → link
    - otherwise → 0
  - operand_2:
    - LUI → {imm,16'b0}
    - ADDIU, LB, LW, LBU, SB, SW → sign-extended imm
    - ANDI, ORI → zero-extended imm
    - SPECIAL → rt_v
    - otherwise → 0
  - link = addr+8, modulo 2^DATA_WIDTH (wraps silently).
- Handshake:
  - in_ready = ~stall & (~out_valid | out_ready).
  - Capture when in_valid & in_ready: operands load, out_valid←1. Latency is 1 cycle from acceptance to out_valid.
  - If out_valid & out_ready and no capture: out_valid←0 (bubble); operands hold their last value.
  - If out_valid & ~out_ready: operands and out_valid hold. Inputs are not sampled.
  - Back-to-back capture with out_ready=1 sustains one instruction per cycle.
  - Upstream must hold its inputs stable while in_valid & ~in_ready. Forwarding inputs are re-evaluated every cycle; the stall releases the cycle fwd_pending drops.

Optional Feature:
- Macro OPGEN_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles (32 bits).
  - Increments each cycle stall=1; saturates at 0xFFFFFFFF; cleared by rst.
- Undefined:
  - Port absent; no counter logic.

Test Plan:
- ADDIU rs=3, reg_data_1=0x10, imm=0xFFFE, no fwd, out_ready=1 → next cycle out_valid=1, operand_1=0x10, operand_2=0xFFFFFFFE.
- SPECIAL ADDU rs=4, rt=4, fwd ch0={addr 4, data 0xAA}, ch1={addr 4, data 0xBB}, reg=0x11 → operand_1=operand_2=0xAA. Repeat with rs=rt=0 and fwd_addr=0 → reg_data values.
- LW rs=5, ch1 pending on reg 5 for 2 cycles, then data 0x1234 → stall=1 and in_ready=0 for 2 cycles. out_valid=0 meanwhile (if out_ready=1). Then capture with operand_1=0x1234, operand_2=sext(imm).
- JAL at addr=0xFFFFFFFC → operand_1=0x00000004, operand_2=0. JALR at 0x400 → operand_1=0x408, operand_2=reg_data_2.
- out_ready=0 for 3 cycles with a valid output and new in_valid → in_ready=0, operands unchanged. out_ready=1 → new instruction captured next edge. Assert rst mid-hold → out_valid=0, operands=0.
- (OPGEN_STALL_CNT_EN) 5 stall cycles → stall_cycles=5; rst → 0.
